// File: rtl/spi_transaction_fsm.sv
// SPI transaction framer: address+R/W byte, then one data byte.
// Optional burst mode via macro SPI_TRANSACTION_FSM_BURST_EN.
module spi_transaction_fsm #(
    parameter int WIDTH = 8,
    parameter int ADDRW = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             sclkPosEdge,
    input  logic             sclkNegEdge,
    input  logic             csN,
    input  logic [WIDTH-1:0] parallelDataIn,
    output logic [ADDRW-1:0] addrOut,
    output logic             addrWe,
    output logic             parallelLoad,
    output logic             dmWe,
    output logic             misoBufe,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GOT_ADDR,
        READ_LOAD,
        READ_SHIFT,
        WRITE_SHIFT,
        WRITE_STORE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CW-1:0]    bit_count;
    logic [CW-1:0]    count_n;
    logic [ADDRW-1:0] addr_n;

    // State, counter, address and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state        <= IDLE;
            bit_count    <= '0;
            addrOut      <= '0;
            addrWe       <= 1'b0;
            parallelLoad <= 1'b0;
            dmWe         <= 1'b0;
            misoBufe     <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            bit_count    <= count_n;
            addrOut      <= addr_n;
            addrWe       <= (state_n == GOT_ADDR);
            parallelLoad <= (state_n == READ_LOAD);
            dmWe         <= (state_n == WRITE_STORE);
            misoBufe     <= (state_n == READ_SHIFT);
            busy         <= (state_n != IDLE);
        end
    end

    // Next state, bit counter and address; chip-select abort wins last.
    always_comb begin
        state_n = state;
        count_n = bit_count;
        addr_n  = addrOut;
        unique case (state)
            IDLE: begin
                if (!csN) begin
                    state_n = GET_ADDR;
                    count_n = '0;
                end
            end
            GET_ADDR: begin
                if (sclkPosEdge) begin
                    count_n = bit_count + 1'b1;
                    if (bit_count == LAST) begin
                        state_n = GOT_ADDR;
                    end
                end
            end
            GOT_ADDR: begin
                count_n = '0;
                addr_n  = parallelDataIn[WIDTH-1:1];
                state_n = parallelDataIn[0] ? READ_LOAD : WRITE_SHIFT;
            end
            READ_LOAD: begin
                state_n = READ_SHIFT;
            end
            READ_SHIFT: begin
                if (sclkNegEdge) begin
                    count_n = bit_count + 1'b1;
                    if (bit_count == LAST) begin
`ifdef SPI_TRANSACTION_FSM_BURST_EN
                        count_n = '0;
                        addr_n  = addrOut + 1'b1;
                        state_n = READ_LOAD;
`else
                        state_n = DONE;
`endif
                    end
                end
            end
            WRITE_SHIFT: begin
                if (sclkPosEdge) begin
                    count_n = bit_count + 1'b1;
                    if (bit_count == LAST) begin
                        state_n = WRITE_STORE;
                    end
                end
            end
            WRITE_STORE: begin
                count_n = '0;
`ifdef SPI_TRANSACTION_FSM_BURST_EN
                addr_n  = addrOut + 1'b1;
                state_n = WRITE_SHIFT;
`else
                state_n = DONE;
`endif
            end
            DONE: begin
                state_n = DONE;
            end
        endcase
        if (state != IDLE && csN) begin
            state_n = IDLE;
            count_n = '0;
            addr_n  = addrOut;
        end
    end

endmodule

// File: tb/tb_spi_transaction_fsm.sv
// Bench for spi_transaction_fsm: queue-based transaction model,
// directed scenarios plus randomized edge/chip-select traffic.
module tb_spi_transaction_fsm;

    logic       clk;
    logic       resetN;
    logic       sclkPosEdge;
    logic       sclkNegEdge;
    logic       csN;
    logic [7:0] parallelDataIn;
    logic [6:0] addrOut;
    logic       addrWe;
    logic       parallelLoad;
    logic       dmWe;
    logic       misoBufe;
    logic       busy;

    spi_transaction_fsm #(.WIDTH(8), .ADDRW(7)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .sclkPosEdge    (sclkPosEdge),
        .sclkNegEdge    (sclkNegEdge),
        .csN            (csN),
        .parallelDataIn (parallelDataIn),
        .addrOut        (addrOut),
        .addrWe         (addrWe),
        .parallelLoad   (parallelLoad),
        .dmWe           (dmWe),
        .misoBufe       (misoBufe),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: a frame is open while CS is low; address bits then data
    // bits are counted; one-clk strobes wait in a queue and block
    // edge counting while pending.
    localparam int AW = 1;
    localparam int PL = 2;
    localparam int WE = 3;

    int         q[$];
    bit         armed = 0;
    bit         m_frame, m_rd, m_done;
    int         m_acnt, m_dcnt;
    logic [6:0] m_addr;
    bit         e_aw, e_pl, e_we, e_mb;
    int         c;

    always @(posedge clk) begin
        if (!resetN) begin
            m_frame = 0; m_rd = 0; m_done = 0;
            m_acnt = 0; m_dcnt = 0; m_addr = 7'h00;
            q.delete();
            armed = 1;
        end else if (m_frame && csN) begin
            m_frame = 0; m_done = 0;
            q.delete();
        end else if (!m_frame) begin
            if (!csN) begin
                m_frame = 1; m_rd = 0; m_done = 0;
                m_acnt = 0; m_dcnt = 0;
            end
        end else if (q.size() > 0) begin
            c = q.pop_front();
            if (c == AW) begin
                m_addr = parallelDataIn[7:1];
                m_rd = parallelDataIn[0];
                m_dcnt = 0;
                if (m_rd) q.push_back(PL);
            end else if (c == WE) begin
`ifdef SPI_TRANSACTION_FSM_BURST_EN
                m_addr = m_addr + 7'd1;
`else
                m_done = 1;
`endif
            end
        end else if (m_done) begin
            m_done = 1;
        end else if (m_acnt < 8) begin
            if (sclkPosEdge) begin
                m_acnt++;
                if (m_acnt == 8) q.push_back(AW);
            end
        end else if (m_rd) begin
            if (sclkNegEdge) begin
                m_dcnt++;
                if (m_dcnt == 8) begin
                    m_dcnt = 0;
`ifdef SPI_TRANSACTION_FSM_BURST_EN
                    m_addr = m_addr + 7'd1;
                    q.push_back(PL);
`else
                    m_done = 1;
`endif
                end
            end
        end else begin
            if (sclkPosEdge) begin
                m_dcnt++;
                if (m_dcnt == 8) begin
                    m_dcnt = 0;
                    q.push_back(WE);
                end
            end
        end
        e_aw = (q.size() > 0) && (q[0] == AW);
        e_pl = (q.size() > 0) && (q[0] == PL);
        e_we = (q.size() > 0) && (q[0] == WE);
        e_mb = m_frame && m_acnt == 8 && m_rd && q.size() == 0 && !m_done;
    end

    int         n_aw = 0, n_pl = 0, n_we = 0;
    logic [6:0] we_addrs[$];

    // Per-cycle comparison against the model, away from the clock edge.
    always @(negedge clk) begin
        if (armed) begin
            vectors++;
            if ({addrWe, parallelLoad, dmWe, misoBufe, busy, addrOut} !==
                {e_aw, e_pl, e_we, e_mb, m_frame, m_addr}) begin
                miscompares++;
                $display("FAIL cycle t=%0t dut aw=%b pl=%b we=%b mb=%b busy=%b addr=%h model aw=%b pl=%b we=%b mb=%b busy=%b addr=%h",
                         $time, addrWe, parallelLoad, dmWe, misoBufe, busy, addrOut,
                         e_aw, e_pl, e_we, e_mb, m_frame, m_addr);
            end
            if (addrWe) n_aw++;
            if (parallelLoad) n_pl++;
            if (dmWe) begin
                n_we++;
                we_addrs.push_back(addrOut);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit cs, input bit pe,
                       input bit ne, input logic [7:0] d);
        resetN = r;
        csN = cs;
        sclkPosEdge = pe;
        sclkNegEdge = ne;
        parallelDataIn = d;
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input int n, input bit pe, input bit ne,
                           input logic [7:0] d);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, pe, ne, d);
            cyc(1, 0, 0, 0, d);
        end
    endtask

    int sz, a0, p0, w0;
    bit cs_v;

    initial begin
        resetN = 0; csN = 1; sclkPosEdge = 0; sclkNegEdge = 0;
        parallelDataIn = 8'h00;
        @(posedge clk); #1;
        cyc(0, 1, 0, 0, 8'h00);
        chk("reset_busy", busy, 0);
        chk("reset_addr", addrOut, 0);
        chk("reset_strobes", {addrWe, parallelLoad, dmWe, misoBufe}, 0);

        // write frame, address byte 8'h54
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h54);
        strobes(7, 1, 0, 8'h54);
        cyc(1, 0, 1, 0, 8'h54);
        chk("write_addrwe", addrWe, 1);
        cyc(1, 0, 0, 0, 8'h54);
        chk("write_addr", addrOut, 7'h2A);
        chk("write_addrwe_once", addrWe, 0);
        sz = we_addrs.size();
        strobes(8, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
        chk("write_dmwe_count", we_addrs.size() - sz, 1);
        chk("write_done_busy", busy, 1);
        cyc(1, 1, 0, 0, 8'h00);
        chk("write_idle_busy", busy, 0);

        // read frame, address byte 8'hA7
        cyc(1, 0, 0, 0, 8'hA7);
        strobes(7, 1, 0, 8'hA7);
        cyc(1, 0, 1, 0, 8'hA7);
        chk("read_addrwe", addrWe, 1);
        cyc(1, 0, 0, 0, 8'hA7);
        chk("read_pload", parallelLoad, 1);
        chk("read_addr", addrOut, 7'h53);
        cyc(1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            chk("read_mb_on", misoBufe, 1);
            cyc(1, 0, 0, 1, 8'h00);
            cyc(1, 0, 0, 0, 8'h00);
        end
        chk("read_mb_off", misoBufe, 0);
        chk("read_done_busy", busy, 1);

        // abort after 5 address edges
        cyc(1, 1, 0, 0, 8'h00);
        a0 = n_aw; p0 = n_pl; w0 = n_we;
        cyc(1, 0, 0, 0, 8'hFF);
        strobes(5, 1, 0, 8'hFF);
        cyc(1, 1, 1, 0, 8'hFF);
        chk("abort_busy", busy, 0);
        cyc(1, 1, 0, 0, 8'h00);
        chk("abort_addr", addrOut, 7'h53);
        chk("abort_strobes", (n_aw - a0) + (n_pl - p0) + (n_we - w0), 0);

        // simultaneous edges: GET_ADDR counts rises, READ_SHIFT falls
        cyc(1, 0, 0, 0, 8'hA7);
        strobes(3, 0, 1, 8'hA7);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, 1, 8'hA7);
        chk("illegal_addr_wait", addrWe, 0);
        cyc(1, 0, 1, 1, 8'hA7);
        chk("illegal_addrwe", addrWe, 1);
        cyc(1, 0, 0, 0, 8'hA7);
        cyc(1, 0, 0, 0, 8'h00);
        strobes(3, 1, 0, 8'h00);
        for (int i = 0; i < 7; i++) cyc(1, 0, 1, 1, 8'h00);
        chk("illegal_mb_on", misoBufe, 1);
        cyc(1, 0, 1, 1, 8'h00);
        chk("illegal_mb_off", misoBufe, 0);

        // reset mid write data (3 bits in)
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h54);
        strobes(8, 1, 0, 8'h54);
        strobes(3, 1, 0, 8'h00);
        cyc(0, 0, 1, 0, 8'h00);
        chk("midreset_busy", busy, 0);
        chk("midreset_addr", addrOut, 0);
        cyc(0, 0, 0, 0, 8'h00);
        chk("midreset_outs", {addrWe, parallelLoad, dmWe, misoBufe, busy}, 0);

        // burst write from 7'h7F, three data bytes
        cyc(1, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'hFE);
        strobes(8, 1, 0, 8'hFE);
        sz = we_addrs.size();
        for (int b = 0; b < 3; b++) strobes(8, 1, 0, 8'h00);
        cyc(1, 0, 0, 0, 8'h00);
`ifdef SPI_TRANSACTION_FSM_BURST_EN
        chk("burst_count", we_addrs.size() - sz, 3);
        if (we_addrs.size() - sz == 3) begin
            chk("burst_a0", we_addrs[sz], 7'h7F);
            chk("burst_a1", we_addrs[sz+1], 7'h00);
            chk("burst_a2", we_addrs[sz+2], 7'h01);
        end
`else
        chk("burst_count", we_addrs.size() - sz, 1);
        if (we_addrs.size() - sz == 1) chk("burst_a0", we_addrs[sz], 7'h7F);
`endif
        cyc(1, 1, 0, 0, 8'h00);

        // randomized traffic
        cs_v = 1;
        for (int k = 0; k < 6000; k++) begin
            if (cs_v) cs_v = ($urandom_range(0, 2) != 0);
            else if (m_done && $urandom_range(0, 3) == 0) cs_v = 1;
            else if ($urandom_range(0, 199) == 0) cs_v = 1;
            cyc($urandom_range(0, 499) != 0, cs_v,
                $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                8'($urandom));
        end
        cyc(1, 1, 0, 0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_transaction_fsm.md
Name: spi_transaction_fsm

Overview:
- Control FSM sitting directly downstream of the 8-bit shiftregister in the Lab2 SPI memory.
- Consumes the conditioned SCLK edge strobes, the conditioned chip select and the shift register's parallelDataOut.
- Frames each SPI transaction: address + R/W byte, then one data byte.
- Drives the shift register's parallelLoad, the data-memory write enable, the address latch enable and the MISO tri-state buffer enable.

Parameters:
- WIDTH, 8, bits per SPI byte; equals shiftregister width.
- ADDRW, 7, address bits, taken as parallelDataIn[WIDTH-1:1]; must equal WIDTH-1.

Ports:
- clk  input  1  system clock (50 MHz).
- resetN  input  1  synchronous active-low reset, sampled on rising clk.
- sclkPosEdge  input  1  one-clk strobe on conditioned SCLK rising edge.
- sclkNegEdge  input  1  one-clk strobe on conditioned SCLK falling edge.
- csN  input  1  conditioned chip select, active low.
- parallelDataIn  input  WIDTH  shiftregister parallelDataOut.
- addrOut  output  ADDRW  latched memory address.
- addrWe  output  1  one-cycle address latch strobe.
- parallelLoad  output  1  one-cycle load strobe to shiftregister (read data).
- dmWe  output  1  one-cycle data-memory write strobe.
- misoBufe  output  1  MISO tri-state enable.
- busy  output  1  high in every state except IDLE.

Behaviour:
- All outputs registered; state changes on rising clk only.
- resetN=0 at a clk edge: state=IDLE, bitCount=0, addrOut=0, all strobes/misoBufe/busy=0. Reset overrides every other input, including mid-transaction.
- csN=1 in any non-IDLE state: next state IDLE, bitCount=0, strobes 0. addrOut holds its value. Priority is below reset, above all else.
- bitCount width is $clog2(WIDTH+1). It counts edge strobes only, never raw clk.
- States and transitions:
  - IDLE: csN=0 -> GET_ADDR, bitCount=0.
  - GET_ADDR: each sclkPosEdge increments bitCount. On the strobe making bitCount==WIDTH -> GOT_ADDR.
  - GOT_ADDR (exactly 1 clk): addrWe=1; addrOut<=parallelDataIn[WIDTH-1:1]; bitCount=0. parallelDataIn[0]=1 -> READ_LOAD, else WRITE_SHIFT.
  - READ_LOAD (exactly 1 clk): parallelLoad=1. The memory read has 1-cycle latency from addrOut. -> READ_SHIFT.
  - READ_SHIFT: misoBufe=1; each sclkNegEdge increments bitCount. On bitCount reaching WIDTH -> DONE (misoBufe drops the same edge).
  - WRITE_SHIFT: each sclkPosEdge increments bitCount. On bitCount reaching WIDTH -> WRITE_STORE.
  - WRITE_STORE (exactly 1 clk): dmWe=1. -> DONE.
  - DONE: all strobes 0, busy=1; wait for csN=1 -> IDLE. Further SCLK edges are ignored.
- Strobe timing: addrWe, parallelLoad and dmWe are high for exactly one clk per occurrence, never overlapping.
- Simultaneous sclkPosEdge and sclkNegEdge: protocol violation. The state in use counts only its own edge type; the other is ignored.
- Edge strobe arriving in the same cycle as the csN=1 abort: ignored.
- Latency: last address SCLK rise strobe -> addrWe 1 clk later -> parallelLoad 2 clks later (read path).

Optional Feature:
- Macro: SPI_TRANSACTION_FSM_BURST_EN.
- Defined, after READ_SHIFT or WRITE_STORE completes with csN still 0:
  - addrOut increments by 1, wrapping 2^ADDRW-1 -> 0.
  - Next state is READ_LOAD (read) or WRITE_SHIFT (write), bitCount=0, instead of DONE.
  - The R/W direction is held from GOT_ADDR for the whole burst.
- Undefined: DONE is entered as described; no address increment logic is synthesized.

Test Plan:
- Reset: resetN=0 for 2 clks mid-WRITE_SHIFT (bitCount=3) -> state IDLE, addrOut=0, all outputs 0, busy=0 next edge.
- Write: csN=0, 8 posedge strobes with parallelDataIn=8'h54 at the 8th -> addrWe pulse, addrOut=7'h2A, WRITE_SHIFT. 8 more posedges -> single dmWe pulse, then DONE. csN=1 -> IDLE.
- Read: address byte 8'hA7 -> addrOut=7'h53, parallelLoad pulse exactly 2 clks after 8th posedge, misoBufe=1 for exactly 8 negedge strobes, then 0.
- Abort: csN=1 after 5 address posedges -> IDLE next clk, no addrWe/dmWe/parallelLoad ever asserted, addrOut unchanged.
- Illegal edges: sclkPosEdge and sclkNegEdge asserted together 8 times in GET_ADDR -> GOT_ADDR reached (posedges counted). In READ_SHIFT the same stimulus counts only negedges.
- Burst (macro defined): write address 7'h7F, 3 data bytes -> 3 dmWe pulses with addrOut=7'h7F, 7'h00, 7'h01. Without the macro, the 2nd and 3rd bytes produce no dmWe.
